// File: rtl/mux3_pkg.sv
// mux3_pkg -- shared definitions for the mux3 block.
//   sel_t            : 2-bit select code type
//   SEL_D0..SEL_RSVD : select code constants (SEL_RSVD also routes to d2)
//   is_rsvd()        : true when a select code is the reserved value
package mux3_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_D0   = 2'd0;
  localparam sel_t SEL_D1   = 2'd1;
  localparam sel_t SEL_D2   = 2'd2;
  localparam sel_t SEL_RSVD = 2'd3;

  function automatic logic is_rsvd(input sel_t sel);
    return (sel == SEL_RSVD);
  endfunction

endpackage

// File: rtl/mux3_outreg.sv
// mux3_outreg -- WIDTH-wide data register with asynchronous active-low reset.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears q immediately
//   d     : data in
//   q     : registered data out
module mux3_outreg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/mux3.sv
// mux3 -- 3-input data selector with a sticky reserved-select flag.
// Configuration macro: MUX3_OUTREG_EN
//   defined   : y is registered (1-cycle latency, cleared by rst_n)
//   undefined : y is purely combinational and ignores clk/rst_n
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   d0/d1/d2: WIDTH-bit data operands (d2 serves s=2 and s=3)
//   s       : 2-bit select code
//   y       : selected data
//   sel_err : sticky, set once s=3 has been sampled after reset release
module mux3
  import mux3_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y,
  output logic             sel_err
);

  sel_t             sel;
  logic [WIDTH-1:0] mux_y;

  assign sel = sel_t'(s);

  // s[1] has priority: both 2 and 3 route to d2.
  always_comb begin
    mux_y = d2;
    case (sel)
      SEL_D0:  mux_y = d0;
      SEL_D1:  mux_y = d1;
      default: mux_y = d2;
    endcase
  end

`ifdef MUX3_OUTREG_EN
  mux3_outreg #(
    .WIDTH (WIDTH)
  ) u_outreg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mux_y),
    .q     (y)
  );
`else
  assign y = mux_y;
`endif

  // armed_reg is 0 on the edge where reset is released, so an s=3 coinciding
  // with the release edge is ignored; from the next edge on, s=3 is latched.
  logic armed_reg;
  logic sel_err_reg;
  logic sel_err_next;

  always_comb begin
    sel_err_next = sel_err_reg;
    if (armed_reg && is_rsvd(sel)) begin
      sel_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_reg   <= 1'b0;
      sel_err_reg <= 1'b0;
    end else begin
      armed_reg   <= 1'b1;
      sel_err_reg <= sel_err_next;
    end
  end

  assign sel_err = sel_err_reg;

endmodule

// File: tb/tb_mux3.sv
// tb_mux3 -- self-checking bench for mux3 at WIDTH=16, 1 and 64.
// Works in either configuration (MUX3_OUTREG_EN defined or not).
module tb_mux3;

  localparam logic [63:0] ONES = '1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  s;
  logic [63:0] d0, d1, d2;

  logic [15:0] y16;
  logic [0:0]  y1;
  logic [63:0] y64;
  logic        err16, err1, err64;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  mux3 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .d0(d0[15:0]), .d1(d1[15:0]), .d2(d2[15:0]),
    .s(s), .y(y16), .sel_err(err16)
  );
  mux3 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .d0(d0[0:0]), .d1(d1[0:0]), .d2(d2[0:0]),
    .s(s), .y(y1), .sel_err(err1)
  );
  mux3 #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .d2(d2),
    .s(s), .y(y64), .sel_err(err64)
  );

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] pick(input logic [1:0] sv,
                                       input logic [63:0] a, b, c);
    if (sv == 2'd0) return a;
    if (sv == 2'd1) return b;
    return c;  // 2 and 3
  endfunction

  int          m_edges = 0;     // rising edges seen since reset release
  logic [63:0] m_y     = '0;    // selection captured at the last edge
  logic        m_err   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges = 0;
      m_y     = '0;
      m_err   = 1'b0;
    end else begin
      m_edges = m_edges + 1;
      m_y     = pick(s, d0, d1, d2);
      if (s == 2'd3 && m_edges >= 2) m_err = 1'b1;
    end
  end

  function automatic logic [63:0] exp_y();
`ifdef MUX3_OUTREG_EN
    return m_y;
`else
    return pick(s, d0, d1, d2);
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic [63:0] e;
    if (cmp_en) begin
      e = exp_y();
      check("cyc_y16", 64'(y16), {48'b0, e[15:0]});
      check("cyc_y1",  64'(y1),  {63'b0, e[0]});
      check("cyc_y64", y64, e);
      check("cyc_err16", 64'(err16), 64'(m_err));
      check("cyc_err1",  64'(err1),  64'(m_err));
      check("cyc_err64", 64'(err64), 64'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [1:0] sv, input logic [63:0] a, b, c);
    @(posedge clk);
    #2;
    s = sv; d0 = a; d1 = b; d2 = c;
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_chk(input string name, input logic [1:0] sv,
                          input logic [63:0] a, b, c, input logic [15:0] exp16);
    drive(sv, a, b, c);
`ifndef MUX3_OUTREG_EN
    #1 check({name, "_now"}, 64'(y16), 64'(exp16));
`endif
    settle();
    check(name, 64'(y16), 64'(exp16));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s = 2'd0; d0 = '0; d1 = '0; d2 = '0;
    #1;
    check("rst_err", 64'(err16), 64'd0);
`ifdef MUX3_OUTREG_EN
    check("rst_y", 64'(y16), 64'd0);
`endif
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Basic selection sweep
    step_chk("s0", 2'd0, 64'h1234, 64'habcd, 64'h1111, 16'h1234);
    step_chk("s1", 2'd1, 64'h1234, 64'habcd, 64'h1111, 16'habcd);
    step_chk("s2", 2'd2, 64'h1234, 64'habcd, 64'h1111, 16'h1111);
    step_chk("s3", 2'd3, 64'h1234, 64'habcd, 64'h1111, 16'h1111);
    check("err_after_s3", 64'(err16), 64'd1);

    // Asynchronous reset in the middle of a period
    step_chk("hold_abcd", 2'd1, 64'h1234, 64'habcd, 64'h1111, 16'habcd);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_err", 64'(err16), 64'd0);
`ifdef MUX3_OUTREG_EN
    check("async_rst_y", 64'(y16), 64'd0);
`else
    check("async_rst_y", 64'(y16), 64'habcd);
`endif

    // Reset released on the same edge that first samples s=3
    repeat (2) @(posedge clk);
    #2;
    s = 2'd3;
    rst_n = 1'b1;
    @(posedge clk);
    #2 s = 2'd0;
    settle();
    check("rel_s3_err16", 64'(err16), 64'd0);
    check("rel_s3_err64", 64'(err64), 64'd0);

    // 2 -> 3 -> 0: flag sets and sticks
    step_chk("seq_s2", 2'd2, 64'h1234, 64'habcd, 64'h1111, 16'h1111);
    check("seq_err_pre", 64'(err16), 64'd0);
    step_chk("seq_s3", 2'd3, 64'h1234, 64'habcd, 64'h1111, 16'h1111);
    check("seq_err_set", 64'(err16), 64'd1);
    step_chk("seq_s0", 2'd0, 64'h1234, 64'habcd, 64'h1111, 16'h1234);
    check("seq_err_sticky", 64'(err16), 64'd1);

    // Width extremes with all-ones / all-zeros patterns
    for (int p = 0; p < 3; p++) begin
      for (int sv = 0; sv < 4; sv++) begin
        case (p)
          0:       drive(2'(sv), ONES, 64'd0, ONES);
          1:       drive(2'(sv), 64'd0, ONES, 64'd0);
          default: drive(2'(sv), 64'd0, 64'd0, ONES);
        endcase
        settle();
      end
    end
    drive(2'd1, ONES, 64'd0, ONES);
    settle();
    check("w64_s1_zero", y64, 64'd0);
    check("w1_s1_zero", 64'(y1), 64'd0);
    drive(2'd3, 64'd0, 64'd0, ONES);
    settle();
    check("w64_s3_ones", y64, ONES);
    check("w1_s3_one", 64'(y1), 64'd1);
    drive(2'd0, ONES, 64'd0, 64'd0);
    settle();
    check("w64_s0_ones", y64, ONES);

    cmp_en = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
